jtag_ir_param: RTL and testbench

- Parametrised JTAG instruction register. It is the successor to the fixed single-bit IR in the boundary-scan chain.
- Provides an IR_WIDTH-bit capture/shift stage, a separate update (shadow) latch, and one-hot instruction decode for the boundary-scan cell and bypass blocks.
- Sits between the TAP controller, which drives the capture/shift/update strobes, and the data-register muxing logic.
- All strobes are synchronous enables on a single clock (TCK domain).

---
 rtl/jtag_pkg.sv | 18 +
 rtl/jtag_ir_decode.sv | 48 ++++
 rtl/jtag_ir_param.sv | 80 ++++++++
 tb/tb_jtag_ir_param.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared constants for the parametrised JTAG instruction register:
// one-hot decode bit positions, decode width and default 4-bit opcodes.
package jtag_pkg;

    localparam int DEC_W      = 5;
    localparam int DEC_BYPASS = 0;
    localparam int DEC_EXTEST = 1;
    localparam int DEC_SAMPLE = 2;
    localparam int DEC_IDCODE = 3;
    localparam int DEC_INTEST = 4;

    localparam logic [3:0] DEF_OPC_EXTEST = 4'b0000;
    localparam logic [3:0] DEF_OPC_SAMPLE = 4'b0001;
    localparam logic [3:0] DEF_OPC_IDCODE = 4'b0010;
    localparam logic [3:0] DEF_OPC_INTEST = 4'b0011;
    localparam logic [3:0] DEF_OPC_BYPASS = 4'b1111;

endpackage

// File: rtl/jtag_ir_decode.sv
// Combinational opcode -> one-hot instruction select with unknown flag.
// Unknown opcodes select bypass. When opcodes collide the lower decode
// index wins. Optional macro: JTAG_IR_IDCODE_EN (enables the IDCODE select;
// without it the IDCODE opcode is treated as unknown).
module jtag_ir_decode
    import jtag_pkg::*;
#(
    parameter int                   IR_WIDTH   = 4,
    parameter logic [IR_WIDTH-1:0]  OPC_EXTEST = IR_WIDTH'(DEF_OPC_EXTEST),
    parameter logic [IR_WIDTH-1:0]  OPC_SAMPLE = IR_WIDTH'(DEF_OPC_SAMPLE),
    parameter logic [IR_WIDTH-1:0]  OPC_IDCODE = IR_WIDTH'(DEF_OPC_IDCODE),
    parameter logic [IR_WIDTH-1:0]  OPC_INTEST = IR_WIDTH'(DEF_OPC_INTEST),
    parameter logic [IR_WIDTH-1:0]  OPC_BYPASS = {IR_WIDTH{1'b1}}
) (
    input  logic [IR_WIDTH-1:0] i_ir,
    output logic [DEC_W-1:0]    o_decode,
    output logic                o_unknown
);

    // Priority match in ascending decode-index order; fall through to bypass.
    always_comb begin
        o_decode  = {DEC_W{1'b0}};
        o_unknown = 1'b0;
        if (i_ir == OPC_BYPASS) begin
            o_decode[DEC_BYPASS] = 1'b1;
        end else if (i_ir == OPC_EXTEST) begin
            o_decode[DEC_EXTEST] = 1'b1;
        end else if (i_ir == OPC_SAMPLE) begin
            o_decode[DEC_SAMPLE] = 1'b1;
`ifdef JTAG_IR_IDCODE_EN
        end else if (i_ir == OPC_IDCODE) begin
            o_decode[DEC_IDCODE] = 1'b1;
`endif
        end else if (i_ir == OPC_INTEST) begin
            o_decode[DEC_INTEST] = 1'b1;
`ifndef JTAG_IR_IDCODE_EN
        end else if (i_ir == OPC_IDCODE) begin
            // IDCODE select disabled in this build: bypass, flagged unknown.
            o_decode[DEC_BYPASS] = 1'b1;
            o_unknown            = 1'b1;
`endif
        end else begin
            o_decode[DEC_BYPASS] = 1'b1;
            o_unknown            = 1'b1;
        end
    end

endmodule

// File: rtl/jtag_ir_param.sv
// Parametrised JTAG instruction register: capture/shift stage, update
// (shadow) latch and one-hot decode driven only from the latched value.
// Optional macro: JTAG_IR_IDCODE_EN (IDCODE becomes reset instruction and
// decode[3] is live; otherwise reset instruction is BYPASS).
module jtag_ir_param
    import jtag_pkg::*;
#(
    parameter int                   IR_WIDTH   = 4,
    parameter logic [IR_WIDTH-1:0]  OPC_EXTEST = IR_WIDTH'(DEF_OPC_EXTEST),
    parameter logic [IR_WIDTH-1:0]  OPC_SAMPLE = IR_WIDTH'(DEF_OPC_SAMPLE),
    parameter logic [IR_WIDTH-1:0]  OPC_IDCODE = IR_WIDTH'(DEF_OPC_IDCODE),
    parameter logic [IR_WIDTH-1:0]  OPC_INTEST = IR_WIDTH'(DEF_OPC_INTEST),
    parameter logic [IR_WIDTH-1:0]  OPC_BYPASS = {IR_WIDTH{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                datain,
    input  logic                capture,
    input  logic                shift,
    input  logic                update,
    input  logic [IR_WIDTH-3:0] status_in,
    output logic                dataout,
    output logic [IR_WIDTH-1:0] ir_out,
    output logic [DEC_W-1:0]    decode,
    output logic                ir_unknown
);

`ifdef JTAG_IR_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] RESET_OPC = OPC_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] RESET_OPC = OPC_BYPASS;
`endif

    // Capture value always ends in 2'b01 so the chain can be checked on TDO.
    localparam logic [IR_WIDTH-1:0] SR_RESET = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    logic [IR_WIDTH-1:0] r_shift;
    logic [IR_WIDTH-1:0] r_ir;

    // Capture/shift stage: capture has priority over shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= SR_RESET;
        end else if (capture) begin
            r_shift <= {status_in, 2'b01};
        end else if (shift) begin
            r_shift <= {datain, r_shift[IR_WIDTH-1:1]};
        end else begin
            r_shift <= r_shift;
        end
    end

    // Update latch: takes the shift stage as it was before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir <= RESET_OPC;
        end else if (update) begin
            r_ir <= r_shift;
        end else begin
            r_ir <= r_ir;
        end
    end

    assign dataout = r_shift[0];
    assign ir_out  = r_ir;

    jtag_ir_decode #(
        .IR_WIDTH   (IR_WIDTH),
        .OPC_EXTEST (OPC_EXTEST),
        .OPC_SAMPLE (OPC_SAMPLE),
        .OPC_IDCODE (OPC_IDCODE),
        .OPC_INTEST (OPC_INTEST),
        .OPC_BYPASS (OPC_BYPASS)
    ) u_decode (
        .i_ir      (r_ir),
        .o_decode  (decode),
        .o_unknown (ir_unknown)
    );

endmodule

// File: tb/tb_jtag_ir_param.sv
// Self-checking bench for jtag_ir_param (default 4-bit build). Expectations
// follow JTAG_IR_IDCODE_EN when the macro is defined for the build.
module tb_jtag_ir_param;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         datain;
    logic         capture;
    logic         shift;
    logic         update;
    logic [W-3:0] status_in;
    logic         dataout;
    logic [W-1:0] ir_out;
    logic [4:0]   decode;
    logic         ir_unknown;

    int errors = 0;
    int checks = 0;

    // Reference state: integer values of the shift stage and latched opcode.
    int m_sr;
    int m_ir;

    jtag_ir_param #(.IR_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .datain     (datain),
        .capture    (capture),
        .shift      (shift),
        .update     (update),
        .status_in  (status_in),
        .dataout    (dataout),
        .ir_out     (ir_out),
        .decode     (decode),
        .ir_unknown (ir_unknown)
    );

    always #5 clk = ~clk;

    // Instruction table lookup: decode index for an opcode, -1 if undefined.
    function automatic int dec_index(input int op);
        if (op == 15) return 0;
        if (op == 0)  return 1;
        if (op == 1)  return 2;
`ifdef JTAG_IR_IDCODE_EN
        if (op == 2)  return 3;
`endif
        if (op == 3)  return 4;
        return -1;
    endfunction

    function automatic int exp_decode(input int op);
        int idx;
        idx = dec_index(op);
        return (idx < 0) ? 1 : (1 << idx);
    endfunction

    function automatic int reset_opcode();
`ifdef JTAG_IR_IDCODE_EN
        return 2;
`else
        return 15;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ir_out"},     {28'd0, ir_out},     m_ir);
        check({tag, ".decode"},     {27'd0, decode},     exp_decode(m_ir));
        check({tag, ".ir_unknown"}, {31'd0, ir_unknown}, (dec_index(m_ir) < 0) ? 1 : 0);
        check({tag, ".dataout"},    {31'd0, dataout},    m_sr & 1);
    endtask

    // One clock with the given strobes; the model applies the same rules.
    task automatic step(input logic c, input logic s, input logic u, input logic d,
                        input logic [W-3:0] st, input string tag);
        int pre_sr;
        capture   = c;
        shift     = s;
        update    = u;
        datain    = d;
        status_in = st;
        @(posedge clk);
        pre_sr = m_sr;
        if (c)      m_sr = (int'(st) * 4) + 1;
        else if (s) m_sr = (int'(d) * (1 << (W - 1))) + (m_sr / 2);
        if (u)      m_ir = pre_sr;
        #1;
        capture = 1'b0;
        shift   = 1'b0;
        update  = 1'b0;
        check_model(tag);
    endtask

    // Shift a W-bit value in LSB first, then latch it.
    task automatic load_ir(input int op, input string tag);
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b0, 1'((op >> i) & 1), 2'b00, tag);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, tag);
    endtask

    // Asynchronous reset asserted between edges; outputs checked before any edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        m_sr = 1;
        m_ir = reset_opcode();
        #1;
        check_model(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        datain    = 1'b0;
        capture   = 1'b0;
        shift     = 1'b0;
        update    = 1'b0;
        status_in = 2'b00;
        m_sr      = 1;
        m_ir      = reset_opcode();
        @(posedge clk);
        #1;
        do_reset("reset");

        // Reset values against fixed constants.
        check("reset.ir_out_const",  {28'd0, ir_out}, 32'(reset_opcode()));
`ifdef JTAG_IR_IDCODE_EN
        check("reset.decode_const",  {27'd0, decode}, 32'h08);
`else
        check("reset.decode_const",  {27'd0, decode}, 32'h01);
`endif
        check("reset.dataout_const", {31'd0, dataout}, 32'd1);

        // Capture then shift zeros: TDO shows 1,0,0,1 during the four shifts.
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, "capture");
        check("cap.tdo0", {31'd0, dataout}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, "shift1");
        check("cap.tdo1", {31'd0, dataout}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, "shift2");
        check("cap.tdo2", {31'd0, dataout}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, "shift3");
        check("cap.tdo3", {31'd0, dataout}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, "shift4");

        // Load EXTEST.
        load_ir(0, "extest");
        check("extest.ir",  {28'd0, ir_out},     32'h0);
        check("extest.dec", {27'd0, decode},     32'h02);
        check("extest.unk", {31'd0, ir_unknown}, 32'd0);

        // Undefined opcode 0101 falls back to bypass.
        load_ir(5, "unknown");
        check("unknown.dec", {27'd0, decode},     32'h01);
        check("unknown.unk", {31'd0, ir_unknown}, 32'd1);

        // Capture and shift together: capture wins, then latch to observe it.
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, "cap_shift");
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, "cap_shift_upd");
        check("cap_shift.ir", {28'd0, ir_out}, 32'hD);

        // Update with shift: latch pre-shift value, shift still happens.
        load_ir(1, "sample");
        check("sample.dec", {27'd0, decode}, 32'h04);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, "upd_shift");
        check("upd_shift.ir", {28'd0, ir_out}, 32'h1);

        // Update with capture: latch pre-capture value.
        load_ir(3, "intest");
        check("intest.dec", {27'd0, decode}, 32'h10);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, "upd_cap");

        // IDCODE opcode behaviour depends on the build option.
        load_ir(2, "idcode");
`ifdef JTAG_IR_IDCODE_EN
        check("idcode.dec", {27'd0, decode},     32'h08);
        check("idcode.unk", {31'd0, ir_unknown}, 32'd0);
`else
        check("idcode.dec", {27'd0, decode},     32'h01);
        check("idcode.unk", {31'd0, ir_unknown}, 32'd1);
`endif

        // Reset in the middle of a partial shift discards it.
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, "partial1");
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "partial2");
        do_reset("reset_mid_shift");
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, "post_reset_upd");
        check("post_reset.ir", {28'd0, ir_out}, 32'h1);

        // Randomised strobes and data against the reference model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                do_reset("rand_reset");
            end else begin
                step($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), "random");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
